// File: rtl/fetch_sequencer.sv
// fetch_sequencer: instruction fetch control between the program counter, the
// instruction memory and decode. At most one memory request is in flight.
// A fetched word is held for decode until it is accepted.
//
// Ports
//   clk, rst_n                       clock, asynchronous active-low reset
//   pc_in                            current program counter value
//   pc_enable, pc_load, pc_addr      PC update strobe, load/increment select, load value
//   imem_req_valid/ready/addr        instruction memory request handshake
//   imem_resp_valid/data             instruction memory response (no backpressure)
//   instr_valid/ready/data/pc        fetched instruction handshake to decode
//   redirect, redirect_addr          single-cycle branch/jump redirect
//   halt                             stop issuing new requests
//   fetch_error                      sticky timeout flag, cleared only by reset
//
// TIMEOUT_CYCLES bounds the number of cycles spent in WAIT or FLUSH without a
// response; 0 disables the timeout.
module fetch_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc_in,
  output logic        pc_enable,
  output logic        pc_load,
  output logic [31:0] pc_addr,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_data,
  output logic [31:0] instr_pc,
  input  logic        redirect,
  input  logic [31:0] redirect_addr,
  input  logic        halt,
  output logic        fetch_error
);

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StWait,
    StHold,
    StFlush,
    StError
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] tmo_q, tmo_d;
  logic [31:0] instr_data_q, instr_data_d;
  logic [31:0] instr_pc_q, instr_pc_d;
  logic [31:0] tmo_inc;
  logic        timeout_hit;

  assign tmo_inc     = tmo_q + 32'd1;
  // Fires on the cycle that completes TIMEOUT_CYCLES waiting cycles.
  assign timeout_hit = (TIMEOUT_CYCLES != 32'd0) && (tmo_inc == TIMEOUT_CYCLES);

  always_comb begin
    state_d        = state_q;
    tmo_d          = tmo_q;
    instr_data_d   = instr_data_q;
    instr_pc_d     = instr_pc_q;
    pc_enable      = 1'b0;
    pc_load        = 1'b0;
    pc_addr        = 32'd0;
    imem_req_valid = 1'b0;
    imem_req_addr  = 32'd0;
    instr_valid    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (!halt) state_d = StReq;
      end

      StReq: begin
        // A redirect withdraws the request unless it is accepted this very cycle.
        imem_req_valid = !redirect || imem_req_ready;
        imem_req_addr  = pc_in;
        if (imem_req_ready) begin
          tmo_d = 32'd0;
          if (redirect) begin
            state_d = StFlush;
          end else begin
            instr_pc_d = pc_in;
            state_d    = StWait;
          end
        end
      end

      StWait: begin
        tmo_d = tmo_inc;
        if (redirect) begin
          // A same-cycle response belongs to the old path and is dropped.
          tmo_d   = 32'd0;
          state_d = imem_resp_valid ? StReq : StFlush;
        end else if (imem_resp_valid) begin
          instr_data_d = imem_resp_data;
          pc_enable    = 1'b1;
          state_d      = StHold;
        end else if (timeout_hit) begin
          state_d = StError;
        end
      end

      StHold: begin
        instr_valid = 1'b1;
        if (redirect) begin
          state_d = StReq;
        end else if (instr_ready) begin
          state_d = halt ? StIdle : StReq;
        end
      end

      StFlush: begin
        tmo_d = tmo_inc;
        if (imem_resp_valid) begin
          state_d = halt ? StIdle : StReq;
        end else if (timeout_hit) begin
          state_d = StError;
        end
      end

      StError: begin
      end

      default: state_d = StIdle;
    endcase

    // Redirect loads the PC from any live state; this overrides the increment.
    if (redirect && (state_q != StError)) begin
      pc_enable = 1'b1;
      pc_load   = 1'b1;
      pc_addr   = redirect_addr;
    end

    // Keep combinational outputs quiet while reset is held.
    if (!rst_n) begin
      pc_enable      = 1'b0;
      pc_load        = 1'b0;
      pc_addr        = 32'd0;
      imem_req_valid = 1'b0;
      imem_req_addr  = 32'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      tmo_q        <= 32'd0;
      instr_data_q <= 32'd0;
      instr_pc_q   <= 32'd0;
    end else begin
      state_q      <= state_d;
      tmo_q        <= tmo_d;
      instr_data_q <= instr_data_d;
      instr_pc_q   <= instr_pc_d;
    end
  end

  assign instr_data  = instr_data_q;
  assign instr_pc    = instr_pc_q;
  assign fetch_error = (state_q == StError);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: a PC register and instruction memory model around
// the DUT, table-driven fetch vectors plus hand-written redirect, halt, timeout
// and reset sequences. Expected deliveries go through a scoreboard queue.
module tb_fetch_sequencer;

  logic        clk;
  logic        rst_n;
  logic [31:0] pc_in;
  logic        pc_enable;
  logic        pc_load;
  logic [31:0] pc_addr;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
  logic        redirect;
  logic [31:0] redirect_addr;
  logic        halt;
  logic        fetch_error;

  fetch_sequencer #(.TIMEOUT_CYCLES(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pc_in          (pc_in),
    .pc_enable      (pc_enable),
    .pc_load        (pc_load),
    .pc_addr        (pc_addr),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data (imem_resp_data),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_data     (instr_data),
    .instr_pc       (instr_pc),
    .redirect       (redirect),
    .redirect_addr  (redirect_addr),
    .halt           (halt),
    .fetch_error    (fetch_error)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } exp_t;

  typedef struct {
    logic [31:0] start;
    int unsigned lat;
    int unsigned dly;
    logic [31:0] exp_data;
    logic [31:0] exp_next;
  } row_t;

  exp_t        sb[$];
  logic [31:0] req_addrs[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_inc, n_load, n_req;
  logic [31:0] pc_model;
  bit          pend, mute;
  int unsigned cnt, lat;
  logic [31:0] pend_addr;

  logic        s_pc_en, s_pc_load, s_req_valid, s_ivalid, s_err;
  logic [31:0] s_pc_addr, s_req_addr, s_idata, s_ipc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'd0) return 32'h0050_0093;
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock cycle: sample at the falling edge, then advance the PC and
  // memory models just after the rising edge.
  task automatic tick();
    logic hs;
    exp_t e;
    @(negedge clk);
    s_pc_en     = pc_enable;
    s_pc_load   = pc_load;
    s_pc_addr   = pc_addr;
    s_req_valid = imem_req_valid;
    s_req_addr  = imem_req_addr;
    s_ivalid    = instr_valid;
    s_idata     = instr_data;
    s_ipc       = instr_pc;
    s_err       = fetch_error;
    if (pc_enable) begin
      if (pc_load) n_load++;
      else n_inc++;
    end
    hs = imem_req_valid && imem_req_ready;
    if (hs) begin
      n_req++;
      req_addrs.push_back(imem_req_addr);
    end
    if (instr_valid && instr_ready) begin
      check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("instr_pc", instr_pc, e.pc);
        check("instr_data", instr_data, e.data);
      end
    end
    @(posedge clk);
    #1;
    if (s_pc_en) pc_model = s_pc_load ? s_pc_addr : pc_model + 32'd4;
    pc_in           = pc_model;
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'd0;
    if (pend) begin
      cnt--;
      if (cnt == 0) begin
        imem_resp_valid = 1'b1;
        imem_resp_data  = mem_word(pend_addr);
        pend            = 1'b0;
      end
    end
    if (hs && !mute) begin
      pend      = 1'b1;
      cnt       = lat;
      pend_addr = s_req_addr;
    end
  endtask

  task automatic do_reset(input logic [31:0] start, input bit stray);
    @(posedge clk);
    #1;
    rst_n          = 1'b0;
    halt           = 1'b1;
    redirect       = 1'b1;
    redirect_addr  = 32'hDEAD_BEE0;
    imem_req_ready = 1'b1;
    instr_ready    = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data = 32'd0;
    pend = 1'b0; cnt = 0; mute = 1'b0; lat = 2;
    pc_model = start; pc_in = start;
    n_inc = 0; n_load = 0; n_req = 0;
    req_addrs.delete();
    sb.delete();
    #2;
    check("rst_ctl", 32'({pc_enable, pc_load, imem_req_valid, instr_valid, fetch_error}), 32'd0);
    check("rst_data", pc_addr | imem_req_addr | instr_data | instr_pc, 32'd0);
    redirect = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    halt  = 1'b0;
    if (stray) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = 32'hBAD0_BAD0;
    end
    tick();
    check("first_cycle_idle", 32'({s_req_valid, s_ivalid, s_err}), 32'd0);
  endtask

  task automatic wait_req(input int n);
    for (int i = 0; i < 30 && n_req < n; i++) tick();
    check("wait_req", 32'(n_req), 32'(n));
  endtask

  task automatic drain();
    instr_ready = 1'b1;
    for (int i = 0; i < 40 && sb.size() != 0; i++) tick();
    check("drain", 32'(sb.size()), 32'd0);
    tick();
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  row_t rows[4];

  initial begin
    rows[0] = '{32'h0000_0000, 2, 5, 32'h0050_0093, 32'h0000_0004};
    rows[1] = '{32'h0000_0010, 1, 0, 32'h0010_FFEF, 32'h0000_0014};
    rows[2] = '{32'h0000_1234, 3, 2, 32'h1234_EDCB, 32'h0000_1238};
    rows[3] = '{32'h0000_FFFC, 2, 1, 32'hFFFC_0003, 32'h0001_0000};

    rst_n = 1'b0; halt = 1'b1; redirect = 1'b0; redirect_addr = 32'd0;
    imem_req_ready = 1'b0; instr_ready = 1'b0; imem_resp_valid = 1'b0;
    imem_resp_data = 32'd0; pc_in = 32'd0; pc_model = 32'd0;

    // Basic fetch, decode backpressure, then halt after delivery.
    for (int r = 0; r < 4; r++) begin
      do_reset(rows[r].start, 1'b0);
      lat = rows[r].lat;
      sb.push_back('{rows[r].start, rows[r].exp_data});
      for (int i = 0; i < 20 && !s_ivalid; i++) tick();
      check("row_valid_seen", 32'(s_ivalid), 32'd1);
      repeat (rows[r].dly) tick();
      check("row_hold_valid", 32'(s_ivalid), 32'd1);
      check("row_hold_data", s_idata, rows[r].exp_data);
      check("row_hold_pc", s_ipc, rows[r].start);
      check("row_hold_nreq", 32'(n_req), 32'd1);
      check("row_hold_pc_model", pc_model, rows[r].exp_next);
      instr_ready = 1'b1;
      halt        = 1'b1;
      tick();
      instr_ready = 1'b0;
      repeat (3) tick();
      check("row_sb_empty", 32'(sb.size()), 32'd0);
      check("row_nreq", 32'(n_req), 32'd1);
      check("row_ninc", 32'(n_inc), 32'd1);
      check("row_next_pc", pc_model, rows[r].exp_next);
    end

    // Redirect while waiting: old response dropped, refetch from target.
    do_reset(32'h8, 1'b0);
    lat = 3;
    wait_req(1);
    redirect = 1'b1; redirect_addr = 32'h100;
    tick();
    redirect = 1'b0;
    check("wait_redir_en_load", 32'({s_pc_en, s_pc_load}), 32'd3);
    check("wait_redir_addr", s_pc_addr, 32'h100);
    wait_req(2);
    halt = 1'b1;
    check("wait_redir_req_addr", req_addrs[1], 32'h100);
    sb.push_back('{32'h100, 32'h0100_FEFF});
    drain();
    check("wait_redir_ninc", 32'(n_inc), 32'd1);
    check("wait_redir_pc", pc_model, 32'h104);

    // Redirect in the same cycle as the response.
    do_reset(32'h8, 1'b0);
    lat = 2;
    wait_req(1);
    for (int i = 0; i < 10 && !imem_resp_valid; i++) tick();
    check("resp_seen", 32'(imem_resp_valid), 32'd1);
    redirect = 1'b1; redirect_addr = 32'h40;
    tick();
    redirect = 1'b0;
    check("resp_redir_en_load", 32'({s_pc_en, s_pc_load}), 32'd3);
    check("resp_redir_ninc", 32'(n_inc), 32'd0);
    wait_req(2);
    halt = 1'b1;
    check("resp_redir_req_addr", req_addrs[1], 32'h40);
    sb.push_back('{32'h40, 32'h0040_FFBF});
    drain();
    check("resp_redir_nload", 32'(n_load), 32'd1);
    check("resp_redir_pc", pc_model, 32'h44);

    // Timeout into the terminal error state.
    do_reset(32'h20, 1'b0);
    mute = 1'b1;
    wait_req(1);
    repeat (4) tick();
    check("tmo_not_yet", 32'(s_err), 32'd0);
    tick();
    check("tmo_error", 32'(s_err), 32'd1);
    redirect = 1'b1; redirect_addr = 32'h300; instr_ready = 1'b1;
    tick();
    redirect = 1'b0;
    check("err_outputs", 32'({s_pc_en, s_pc_load, s_req_valid, s_ivalid, s_err}), 32'd1);
    repeat (3) tick();
    check("err_sticky", 32'(s_err), 32'd1);
    check("err_nreq", 32'(n_req), 32'd1);

    // Halt during WAIT: instruction still delivered, then no new request.
    do_reset(32'h30, 1'b0);
    lat = 3;
    wait_req(1);
    halt = 1'b1;
    sb.push_back('{32'h30, 32'h0030_FFCF});
    instr_ready = 1'b1;
    repeat (10) tick();
    check("halt_delivered", 32'(sb.size()), 32'd0);
    check("halt_nreq", 32'(n_req), 32'd1);
    check("halt_req_idle", 32'(s_req_valid), 32'd0);
    halt = 1'b0;
    wait_req(2);
    halt = 1'b1;
    check("halt_resume_addr", req_addrs[1], 32'h34);
    sb.push_back('{32'h34, 32'h0034_FFCB});
    drain();

    // Redirect in REQ without ready withdraws the request.
    do_reset(32'h50, 1'b0);
    imem_req_ready = 1'b0;
    redirect = 1'b1; redirect_addr = 32'h70;
    tick();
    redirect = 1'b0;
    check("req_redir_ctl", 32'({s_req_valid, s_pc_en, s_pc_load}), 32'd3);
    check("req_redir_addr", s_pc_addr, 32'h70);
    tick();
    check("req_after_redir_valid", 32'(s_req_valid), 32'd1);
    check("req_after_redir_addr", s_req_addr, 32'h70);
    imem_req_ready = 1'b1;
    wait_req(1);
    halt = 1'b1;
    check("req_redir_first_addr", req_addrs[0], 32'h70);
    sb.push_back('{32'h70, 32'h0070_FF8F});
    drain();

    // Redirect in HOLD together with a decode transfer.
    do_reset(32'h0, 1'b0);
    lat = 1;
    for (int i = 0; i < 20 && !s_ivalid; i++) tick();
    check("hold_valid_seen", 32'(s_ivalid), 32'd1);
    sb.push_back('{32'h0, 32'h0050_0093});
    sb.push_back('{32'h200, 32'h0200_FDFF});
    instr_ready = 1'b1; redirect = 1'b1; redirect_addr = 32'h200;
    tick();
    redirect = 1'b0; instr_ready = 1'b0;
    tick();
    check("hold_redir_drop", 32'({s_ivalid, s_req_valid}), 32'd1);
    check("hold_redir_req_addr", s_req_addr, 32'h200);
    halt = 1'b1;
    drain();
    check("hold_redir_ninc", 32'(n_inc), 32'd2);
    check("hold_redir_pc", pc_model, 32'h204);

    // Reset mid-transaction, stray responses in IDLE and REQ ignored.
    do_reset(32'h60, 1'b0);
    mute = 1'b1;
    wait_req(1);
    repeat (2) tick();
    do_reset(32'h80, 1'b1);
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'hBAD0_BAD0;
    wait_req(1);
    halt = 1'b1;
    check("rst_mid_req_addr", req_addrs[0], 32'h80);
    sb.push_back('{32'h80, 32'h0080_FF7F});
    drain();
    check("rst_mid_ninc", 32'(n_inc), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter SHALL be: TIMEOUT_CYCLES, default 255, maximum WAIT/FLUSH cycles before fetch error; 0 disables the timeout.
REQ-002 Port SHALL be: clk  in  1  rising-edge clock.
REQ-003 Port SHALL be: rst_n  in  1  asynchronous, active-low reset.
REQ-004 Port SHALL be: pc_in  in  32  current value of the program counter.
REQ-005 Port SHALL be: pc_enable  out  1  program counter update strobe.
REQ-006 Port SHALL be: pc_load  out  1  selects pc_addr load (1) or +4 increment (0).
REQ-007 Port SHALL be: pc_addr  out  32  program counter load value.
REQ-008 Port SHALL be: imem_req_valid / imem_req_ready  out/in  1/1  instruction memory request handshake.
REQ-009 Port SHALL be: imem_req_addr  out  32  request address.
REQ-010 Port SHALL be: imem_resp_valid / imem_resp_data  in/in  1/32  instruction memory response; no backpressure.
REQ-011 Port SHALL be: instr_valid / instr_ready  out/in  1/1  handshake to decode.
REQ-012 Port SHALL be: instr_data / instr_pc  out/out  32/32  fetched word and its address.
REQ-013 Port SHALL be: redirect / redirect_addr  in/in  1/32  branch/jump redirect, single-cycle pulse.
REQ-014 Port SHALL be: halt  in  1  stop issuing new requests.
REQ-015 Port SHALL be: fetch_error  out  1  sticky timeout flag.

Function
REQ-016 FSM SHALL have states IDLE, REQ, WAIT, HOLD, FLUSH, ERROR; at most one request outstanding.
REQ-017 IDLE: halt=0 -> REQ next cycle; otherwise remain IDLE.
REQ-018 REQ: imem_req_valid=1 and imem_req_addr=pc_in; on ready, pc_in captured as instr_pc -> WAIT.
REQ-019 imem_req_valid and imem_req_addr SHALL remain stable until ready, except on a redirect cycle.
REQ-020 WAIT: on imem_resp_valid, data latched into instr_data, pc_enable=1 with pc_load=0 in the same cycle -> HOLD.
REQ-021 HOLD: instr_valid=1 (registered); on instr_valid&&instr_ready -> IDLE if halt=1, else REQ.
REQ-022 A redirect in any non-ERROR state SHALL drive pc_enable=1, pc_load=1, pc_addr=redirect_addr combinationally that cycle.
REQ-023 Redirect in REQ without ready: imem_req_valid forced 0 that cycle, remain REQ.
REQ-024 Redirect in REQ with ready same cycle: request counts as issued -> FLUSH.
REQ-025 Redirect in WAIT without response -> FLUSH; with response same cycle: response discarded, no increment -> REQ.
REQ-026 Redirect in HOLD: a same-cycle instr_ready transfer counts as completed; instr_valid drops next cycle -> REQ.
REQ-027 Redirect in IDLE: PC loaded; state transition per REQ-017.
REQ-028 Redirect in FLUSH: PC loaded; remain FLUSH.
REQ-029 FLUSH: next imem_resp_valid discarded, no pc_enable -> IDLE if halt=1, else REQ.
REQ-030 halt SHALL NOT abort an outstanding request or a held instruction.
REQ-031 Timeout counter cleared on entry to WAIT/FLUSH, increments each cycle there.
REQ-032 When the timeout count equals TIMEOUT_CYCLES (nonzero) without a response -> ERROR; fetch_error=1.
REQ-033 ERROR: terminal until reset; all valid/enable outputs 0; redirect ignored.
REQ-034 pc_enable SHALL assert at most once per cycle and only per REQ-020/REQ-022.

Reset
REQ-035 rst_n=0 SHALL asynchronously force state IDLE, timeout counter 0, and every output 0 (pc_enable, pc_load, pc_addr, imem_req_valid, imem_req_addr, instr_valid, instr_data, instr_pc, fetch_error).
REQ-036 Reset mid-transaction SHALL discard any outstanding request; a response arriving after deassertion while in IDLE/REQ SHALL be ignored.
REQ-037 First request SHALL issue no earlier than the second rising edge after rst_n deasserts with halt=0.

Verification
REQ-038 pc_in=0x0, ready=1, response 0x00500093 after 2 cycles -> instr_valid with instr_pc=0x0, instr_data=0x00500093; one pc_enable/load=0 pulse.
REQ-039 Decode holds instr_ready=0 for 5 cycles -> instr_valid and data stable; no new request; PC not advanced again.
REQ-040 Redirect to 0x100 while in WAIT at pc 0x8 -> pc_load pulse with pc_addr=0x100; next response discarded; next request addr=0x100.
REQ-041 Redirect and imem_resp_valid in the same WAIT cycle -> no instr_valid, no increment; next request addr=redirect_addr.
REQ-042 TIMEOUT_CYCLES=4, no response -> fetch_error=1 after 4 WAIT cycles; outputs idle; cleared only by rst_n=0.
REQ-043 halt=1 during WAIT -> instruction delivered, then IDLE with no further imem_req_valid until halt=0.
